// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-8 Booth mantissa multiplier:
// encoder/selector payloads, accumulator FSM states and datapath widths.
package booth_pkg;

   localparam int BOOTH_N   = 23;
   localparam int NUM_PP    = 9;
   localparam int PP_W      = BOOTH_N + 3;
   localparam int PRODUCT_W = 2*BOOTH_N + 2;
   localparam int ACCUM_W   = 2*BOOTH_N + 5;
   localparam int PP_CNT_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;

   // Radix-8 digit from the encoder: magnitude 0..4 plus sign.
   typedef struct packed {
      logic [2:0] mag;
      logic       neg;
   } t_enc_out;

   // Selector output: 1's-complemented magnitude when neg is set.
   typedef struct packed {
      logic [PP_W-1:0] value;
      logic            neg;
   } t_bs_comp_out;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } t_acc_state;

   // Shift amount for partial product k of a radix-8 recoding.
   function automatic logic [PP_CNT_W+1:0] pp_shift(input logic [PP_CNT_W-1:0] k);
      logic [PP_CNT_W+1:0] kx;
      kx = {2'b00, k};
      return (kx << 1) + kx;
   endfunction

endpackage

// File: rtl/pp_term_gen.sv
// Turns one selector partial product into its weighted accumulator term:
// sign-extend, add neg to complete the 2's complement, shift by 3k.
module pp_term_gen
   import booth_pkg::*;
#(
   parameter int ACC_W = ACCUM_W,
   parameter int CNT_W = PP_CNT_W
) (
   input  t_bs_comp_out     i_pp,
   input  logic [CNT_W-1:0] i_k,
   output logic [ACC_W-1:0] o_term
);

   localparam int PPX_W = $bits(t_bs_comp_out);

   logic signed [ACC_W-1:0] sext_val;
   logic signed [ACC_W-1:0] comp_val;
   logic        [CNT_W+1:0] shamt;

   always_comb begin
      sext_val = {{(ACC_W-PPX_W){i_pp.neg}}, i_pp.neg, i_pp.value};
      comp_val = sext_val + {{(ACC_W-1){1'b0}}, i_pp.neg};
      shamt    = {2'b00, i_k} + ({2'b00, i_k} << 1);
      o_term   = comp_val << shamt;
   end

endmodule

// File: rtl/pp_accumulator.sv
// Sequential accumulator for radix-8 Booth partial products: sums NUM_PP
// weighted terms, then holds the product until downstream takes it.
module pp_accumulator
   import booth_pkg::*;
#(
   parameter int N      = BOOTH_N,
   parameter int NUM_PP = booth_pkg::NUM_PP
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_pp_valid,
   input  t_bs_comp_out      i_pp,
   output logic              o_pp_ready,
   output logic [2*N+1:0]    o_product,
   output logic              o_valid,
   input  logic              i_ready
);

   localparam int ACC_W = 2*N + 5;
   localparam int OUT_W = 2*N + 2;
   localparam int CNT_W = (NUM_PP > 1) ? $clog2(NUM_PP) : 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_PP - 1);

   t_acc_state       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] term;

   pp_term_gen #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_term (
      .i_pp   (i_pp),
      .i_k    (cnt_q),
      .o_term (term)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      o_pp_ready = 1'b0;
      o_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            o_pp_ready = 1'b1;
            if (i_pp_valid) begin
               acc_d = acc_q + term;
               // Counter parks on the last index instead of wrapping.
               if (cnt_q == LAST_K) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Upper guard bits absorb the transient negative partial sums.
   assign o_product = acc_q[OUT_W-1:0];

endmodule

// File: tb/tb_pp_accumulator.sv
// Bench for pp_accumulator: Booth-recoded random operands checked against m*y,
// raw random partial products checked against a plain signed-sum model.
module tb_pp_accumulator;
   import booth_pkg::*;

   localparam int NPP = 9;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         pp_valid = 1'b0;
   logic         ready = 1'b0;
   t_bs_comp_out pp = '0;
   logic         pp_ready;
   logic         valid;
   logic [47:0]  product;

   int checks = 0;
   int errors = 0;

   logic [26:0] pp_buf [NPP];

   always #5 clk = ~clk;

   pp_accumulator dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_pp_valid (pp_valid),
      .i_pp       (pp),
      .o_pp_ready (pp_ready),
      .o_product  (product),
      .o_valid    (valid),
      .i_ready    (ready)
   );

   // Radix-8 recoding of y; each digit times m becomes one selector output.
   function automatic void booth_fill(input logic [23:0] m, input logic [23:0] y);
      logic [27:0] yy;
      logic [25:0] mag;
      int d;
      int dabs;
      yy = {3'b000, y, 1'b0};
      for (int k = 0; k < NPP; k++) begin
         d = -4*int'(yy[3*k+3]) + 2*int'(yy[3*k+2]) + int'(yy[3*k+1]) + int'(yy[3*k]);
         dabs = (d < 0) ? -d : d;
         mag = 26'(longint'(dabs) * longint'(m));
         pp_buf[k] = (d < 0) ? {~mag, 1'b1} : {mag, 1'b0};
      end
   endfunction

   function automatic logic [47:0] model_sum();
      longint acc;
      logic signed [26:0] s;
      longint t;
      acc = 0;
      for (int k = 0; k < NPP; k++) begin
         s = {pp_buf[k][0], pp_buf[k][26:1]};
         t = longint'(s) + longint'(pp_buf[k][0]);
         acc += t <<< (3*k);
      end
      return 48'(acc);
   endfunction

   function automatic void clear_buf();
      for (int k = 0; k < NPP; k++) pp_buf[k] = '0;
   endfunction

   // Runs one accumulation up to DONE. lat counts cycles with the i_start cycle as 1.
   task automatic do_op(input int gap_pct, input bit noise, output logic [47:0] prod,
                        output int lat, output int last_xfer, output bit timed_out);
      int idx;
      int cyc;
      idx = 0;
      last_xfer = 0;
      @(negedge clk);
      start = 1'b1; pp_valid = 1'b0; ready = 1'b0;
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      cyc = 2;
      while (!valid && cyc < 300) begin
         if (pp_ready && idx < NPP && $urandom_range(99) >= gap_pct) begin
            pp = t_bs_comp_out'(pp_buf[idx]);
            pp_valid = 1'b1;
            idx++;
            last_xfer = cyc;
         end else begin
            pp_valid = 1'b0;
            pp = t_bs_comp_out'(27'($urandom));
         end
         start = noise ? 1'($urandom_range(1)) : 1'b0;
         @(negedge clk);
         cyc++;
      end
      pp_valid = 1'b0;
      start = 1'b0;
      timed_out = !valid;
      lat = cyc;
      if (noise && valid) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      prod = product;
   endtask

   task automatic handoff();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || pp_ready !== 1'b0 || product !== 48'h0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b product=%0h expected 0/0/0", valid, pp_ready, product);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero();
      logic [47:0] p;
      int lat, lx;
      bit to;
      clear_buf();
      do_op(0, 1'b0, p, lat, lx, to);
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout: got %b expected 0", to); end
      checks++;
      if (lat !== 11) begin errors++; $display("FAIL zero_latency: got %0d expected 11", lat); end
      checks++;
      if (lat - lx !== 1) begin errors++; $display("FAIL zero_xfer_to_valid: got %0d expected 1", lat - lx); end
      checks++;
      if (p !== 48'h0) begin errors++; $display("FAIL zero_product: got %0h expected 0", p); end
      handoff();
   endtask

   task automatic test_directed();
      logic [47:0] p;
      int lat, lx;
      bit to;
      clear_buf();
      pp_buf[0] = {26'd8, 1'b0};
      pp_buf[1] = {26'h3FFFFFE, 1'b1};
      do_op(0, 1'b0, p, lat, lx, to);
      checks++;
      if (to || p !== 48'd0) begin errors++; $display("FAIL dir_cancel: got %0h expected 0 (timeout=%b)", p, to); end
      handoff();
      clear_buf();
      pp_buf[0] = {26'd5, 1'b0};
      pp_buf[1] = {26'd2, 1'b0};
      do_op(0, 1'b0, p, lat, lx, to);
      checks++;
      if (to || p !== 48'd21) begin errors++; $display("FAIL dir_sum21: got %0d expected 21 (timeout=%b)", p, to); end
      handoff();
   endtask

   task automatic test_random_products();
      logic [23:0] m, y;
      logic [47:0] p, expv;
      int lat, lx;
      bit to;
      for (int i = 0; i < 8; i++) begin
         m = (i == 0) ? 24'hFFFFFF : 24'($urandom);
         y = (i == 0) ? 24'hFFFFFF : (i == 1) ? 24'h924924 : 24'($urandom);
         booth_fill(m, y);
         expv = 48'(longint'(m) * longint'(y));
         do_op(30, 1'b0, p, lat, lx, to);
         checks++;
         if (to || p !== expv) begin
            errors++;
            $display("FAIL rand_product[%0d]: got %0h expected %0h (m=%0h y=%0h timeout=%b)", i, p, expv, m, y, to);
         end
         handoff();
      end
   endtask

   task automatic test_raw_random();
      logic [47:0] p, expv;
      int lat, lx;
      bit to;
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < NPP; k++) pp_buf[k] = 27'($urandom);
         expv = model_sum();
         do_op(0, 1'b0, p, lat, lx, to);
         checks++;
         if (to || p !== expv) begin
            errors++;
            $display("FAIL raw_sum[%0d]: got %0h expected %0h (timeout=%b)", i, p, expv, to);
         end
         handoff();
      end
   endtask

   task automatic test_backpressure();
      logic [47:0] p, expv;
      int lat, lx;
      bit to;
      booth_fill(24'h123456, 24'hABCDEF);
      expv = 48'(longint'(24'h123456) * longint'(24'hABCDEF));
      do_op(0, 1'b0, p, lat, lx, to);
      ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (valid !== 1'b1 || product !== expv) begin
            errors++;
            $display("FAIL hold[%0d]: valid=%b product=%0h expected 1/%0h", c, valid, product, expv);
         end
         @(negedge clk);
      end
      handoff();
      checks++;
      if (valid !== 1'b0 || pp_ready !== 1'b0 || product !== expv) begin
         errors++;
         $display("FAIL idle_after_handoff: valid=%b ready=%b product=%0h expected 0/0/%0h", valid, pp_ready, product, expv);
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] p, expv;
      int lat, lx;
      bit to;
      booth_fill(24'hC0FFEE, 24'h7A5A5A);
      expv = 48'(longint'(24'hC0FFEE) * longint'(24'h7A5A5A));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pp = t_bs_comp_out'(pp_buf[k]);
         pp_valid = 1'b1;
         @(negedge clk);
      end
      rst = 1'b1; start = 1'b1; ready = 1'b1;
      pp = t_bs_comp_out'(pp_buf[4]);
      @(negedge clk);
      rst = 1'b0; start = 1'b0; ready = 1'b0; pp_valid = 1'b0;
      checks++;
      if (pp_ready !== 1'b0 || valid !== 1'b0 || product !== 48'h0) begin
         errors++;
         $display("FAIL mid_reset: ready=%b valid=%b product=%0h expected 0/0/0", pp_ready, valid, product);
      end
      @(negedge clk);
      checks++;
      if (pp_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: ready=%b expected 0", pp_ready); end
      do_op(20, 1'b0, p, lat, lx, to);
      checks++;
      if (to || p !== expv) begin errors++; $display("FAIL after_reset_product: got %0h expected %0h (timeout=%b)", p, expv, to); end
      handoff();
   endtask

   task automatic test_start_ignored();
      logic [47:0] pa, pb, expv;
      int lat, lx;
      bit to_a, to_b;
      booth_fill(24'h89ABCD, 24'hF0F0F1);
      expv = 48'(longint'(24'h89ABCD) * longint'(24'hF0F0F1));
      do_op(0, 1'b0, pa, lat, lx, to_a);
      handoff();
      do_op(40, 1'b1, pb, lat, lx, to_b);
      checks++;
      if (to_a || to_b || pb !== pa || pb !== expv) begin
         errors++;
         $display("FAIL start_ignored: got %0h expected %0h (gap-free %0h)", pb, expv, pa);
      end
      checks++;
      if (valid !== 1'b1) begin errors++; $display("FAIL done_after_start: valid=%b expected 1", valid); end
      handoff();
   endtask

   task automatic test_back_to_back();
      logic [47:0] p, expv;
      int lat, lx;
      bit to;
      for (int i = 0; i < 3; i++) begin
         booth_fill(24'($urandom), 24'($urandom));
         expv = model_sum();
         do_op(0, 1'b0, p, lat, lx, to);
         checks++;
         if (to || p !== expv || lat !== 11) begin
            errors++;
            $display("FAIL b2b[%0d]: got %0h lat %0d expected %0h lat 11", i, p, lat, expv);
         end
         handoff();
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_directed();
      test_random_products();
      test_raw_random();
      test_backpressure();
      test_reset_mid();
      test_start_ignored();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
